// File: rtl/seq_pattern_tx_if.sv
// Request and serial-output bundle for seq_pattern_tx.
//   master : requester side. Drives start_valid, pattern, len and rpt.
//            Observes start_ready and the serial outputs.
//   slave  : transmitter side (seq_pattern_tx).
// Signals:
//   start_valid / start_ready : request handshake.
//   pattern [WIDTH]           : pattern bits, LSB-aligned.
//   len     [LEN_W]           : pattern length in bits.
//   rpt     [CNT_W]           : number of repetitions.
//   out, out_valid            : serial data and its qualifier.
//   busy                      : transmission in progress.
//   done                      : one-cycle pulse after the final bit.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 3,
    parameter int CNT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] rpt;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, pattern, len, rpt,
        input  start_ready, out, out_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, len, rpt,
        output start_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter.
// A request (pattern, len, rpt) is captured on a start_valid && start_ready
// edge. The pattern is then shifted out MSB-first (bit L-1 first), one bit
// per clock, rpt times. GAP idle cycles are inserted between repetitions.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : seq_pattern_tx_if.slave (request handshake and serial outputs)
// All outputs are decoded from registered state only.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic           clk,
    input  logic           reset,
    seq_pattern_tx_if.slave bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_FIN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pat_reg;
    logic [IDX_W-1:0] last_reg;   // index of the first bit sent (L-1)
    logic [IDX_W-1:0] bit_reg;    // index of the bit currently on the line
    logic [CNT_W-1:0] rpt_reg;    // repetitions still to start after the current one
    logic [GAP_W-1:0] gap_reg;    // idle cycles remaining in the gap, minus one

    logic             start_ready;
    logic             accept;
    logic             last_bit;
    logic             more_reps;
    logic [IDX_W-1:0] eff_last;

    assign start_ready = (state_reg == S_IDLE) || (state_reg == S_FIN);
    assign accept      = bus.start_valid && start_ready;
    assign last_bit    = (bit_reg == '0);
    assign more_reps   = (rpt_reg != '0);

    // A length of zero or one above WIDTH selects the full register width.
    assign eff_last = (bus.len == '0 || bus.len > LEN_W'(WIDTH))
                      ? IDX_W'(WIDTH - 1)
                      : IDX_W'(bus.len - LEN_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_FIN: begin
                if (bus.start_valid) begin
                    state_next = (bus.rpt == '0) ? S_FIN : S_SHIFT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (!more_reps) begin
                        state_next = S_FIN;
                    end else if (GAP > 0) begin
                        state_next = S_GAP;
                    end else begin
                        state_next = S_SHIFT;
                    end
                end
            end
            S_GAP: begin
                if (gap_reg == '0) begin
                    state_next = S_SHIFT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg  <= '0;
            last_reg <= '0;
            bit_reg  <= '0;
            rpt_reg  <= '0;
            gap_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_FIN: begin
                    if (accept) begin
                        pat_reg  <= bus.pattern;
                        last_reg <= eff_last;
                        bit_reg  <= eff_last;
                        rpt_reg  <= (bus.rpt == '0) ? '0 : bus.rpt - CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (!last_bit) begin
                        bit_reg <= bit_reg - IDX_W'(1);
                    end else if (more_reps) begin
                        // The index is reloaded now. The gap state does not
                        // shift, so the next burst starts at L-1 in both cases.
                        rpt_reg <= rpt_reg - CNT_W'(1);
                        bit_reg <= last_reg;
                        gap_reg <= GAP_W'((GAP > 0) ? GAP - 1 : 0);
                    end
                end
                S_GAP: begin
                    if (gap_reg != '0) begin
                        gap_reg <= gap_reg - GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = start_ready;
    assign bus.out_valid   = (state_reg == S_SHIFT);
    assign bus.out         = (state_reg == S_SHIFT) && pat_reg[bit_reg];
    assign bus.busy        = (state_reg == S_SHIFT) || (state_reg == S_GAP);
    assign bus.done        = (state_reg == S_FIN);
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Bit-serial pattern transmitter. It is the source side of the team's serial sequence detectors.
- Accepts a pattern word, a length and a repeat count through a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, on a single serial line with a qualifying valid.
- Used to drive detector inputs in loopback and to generate framed test sequences on-chip.

Parameters:
- WIDTH, 4: pattern register width in bits; maximum pattern length.
- LEN_W, 3: width of the len port; must satisfy 2^LEN_W > WIDTH.
- CNT_W, 4: width of the repeat-count port.
- GAP, 1: number of idle cycles (out_valid=0) inserted between consecutive repetitions; 0 allowed.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start_valid  input  1  request to start a transmission
- start_ready  output  1  block can accept a request this cycle
- pattern  input  WIDTH  pattern bits, LSB-aligned; bit len-1 is sent first
- len  input  LEN_W  pattern length in bits
- rpt  input  CNT_W  number of times the pattern is sent
- out  output  1  serial data
- out_valid  output  1  out carries a pattern bit this cycle
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse after the final bit

Behaviour:

Clock and reset
- One clock: clk.
- reset is asynchronous and active-high and takes effect immediately, without waiting for a clock edge.
- Reset values: state=IDLE, start_ready=1, out=0, out_valid=0, busy=0, done=0. Pattern, bit and repeat counters are cleared to 0.
- All outputs are registered or decoded from state only. No input-to-output combinational path exists.

FSM states
- IDLE: start_ready=1, busy=0, done=0.
- SHIFT: out_valid=1, busy=1, out = current pattern bit.
- GAP: out_valid=0, out=0, busy=1.
- FIN: done=1, start_ready=1, busy=0. Lasts exactly one cycle unless a new request is accepted.

Handshake
- A request is accepted on a rising edge where start_valid && start_ready.
- pattern, len and rpt are captured at that edge only. Later changes on these ports have no effect.
- start_valid is ignored while start_ready=0.

Length and repeat rules
- Effective length L = WIDTH if len==0 or len>WIDTH; otherwise L = len.
- rpt==0: the request is accepted and the block goes IDLE->FIN directly. No bit is sent and done pulses in the following cycle.

Transitions
- IDLE/FIN -> SHIFT on acceptance with rpt!=0.
- IDLE/FIN -> FIN on acceptance with rpt==0.
- FIN -> IDLE with no request.
- SHIFT stays in SHIFT for L cycles. The bit index counts down from L-1 to 0.
- On the last bit, SHIFT goes to:
  - GAP, if repetitions remain and GAP>0;
  - SHIFT (index reloaded to L-1), if repetitions remain and GAP==0;
  - FIN, if no repetitions remain.
- GAP stays in GAP for GAP cycles, then returns to SHIFT with index L-1.

Latency and framing
- First bit appears in the cycle after the accepting edge (latency 1).
- Total cycles from first bit to done = L*rpt + GAP*(rpt-1).
- Back-to-back operation: a request accepted in FIN makes the next cycle SHIFT with the new first bit. There is no dead cycle.

Output qualification
- out is forced to 0 whenever out_valid=0.
- done and out_valid are never high in the same cycle.

Reset mid-operation
- Transmission is aborted immediately: out_valid=0, out=0, busy=0.
- done does not pulse.
- Captured values are discarded.

Test Plan:
1. WIDTH=4, GAP=1; pattern=4'b1010, len=4, rpt=1 accepted at edge 0 -> out=1,0,1,0 with out_valid=1 in cycles 1-4; done=1 in cycle 5 only; busy=1 in cycles 1-4.
2. pattern=4'b0101, len=3, rpt=3, GAP=1 -> out_valid pattern 111 0 111 0 111 with data 1,0,1 in each burst; done in cycle 12 (=3*3+2+1).
3. Same request with GAP=0, rpt=2 -> 6 consecutive valid bits 1,0,1,1,0,1; done in cycle 7.
4. len=0 and len=6 each with pattern=4'b1100, rpt=1 -> both send 1,1,0,0. rpt=0 -> done one cycle after acceptance, out_valid never asserted.
5. start_valid held high throughout -> start_ready=0 during cycles 1-4; second request accepted at the FIN edge; its first bit follows done with no gap. pattern/len changes while busy do not alter the output.
6. Assert reset asynchronously mid-cycle during bit 2 of rpt=2 -> out_valid, out and busy drop immediately; no done pulse; start_ready=1. A fresh request afterwards transmits correctly from bit L-1.
